fir2d_kxk_filter: RTL and testbench

// - Parametrised KxK 2D FIR (convolution) on an 8-bit luma video stream. It replaces the fixed
//   4-row buffer skeleton.
// - Sits between the RGB->Y converter and the video output stage, with the same dv/hs/vs stream

---
 rtl/fir2d_pkg.sv | 29 ++
 rtl/fir2d_line_buffer.sv | 43 ++++
 rtl/fir2d_kxk_filter.sv | 233 +++++++++++++++++++++++
 tb/tb_fir2d_kxk_filter.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fir2d_pkg.sv
// rtl/fir2d_pkg.sv - shared constants, types and helpers for the KxK 2D FIR filter
package fir2d_pkg;

    // Fixed pipeline depth: window load | multiply | adder tree | round/saturate.
    localparam int LAT = 4;

    // Default kernel geometry and coefficient width.
    localparam int K_DEF      = 3;
    localparam int COEF_W_DEF = 8;

    // Coefficient bank for the default geometry, index = row*K+col, row 0 = oldest line.
    typedef logic signed [COEF_W_DEF-1:0] coef_bank_t [K_DEF*K_DEF];

    // Accumulator width: signed pixel times signed coefficient, plus growth for K*K terms.
    function automatic int fir2d_acc_w(input int pix_w, input int coef_w, input int k);
        return pix_w + 1 + coef_w + $clog2(k * k);
    endfunction

    // Identity kernel: unity gain (2**shift) on the centre tap, zero elsewhere.
    function automatic int fir2d_identity(input int idx, input int k, input int shift);
        return (idx == (k * k) / 2) ? (1 << shift) : 0;
    endfunction

    // Round-half-up offset added before the normalising shift.
    function automatic int fir2d_round_add(input int shift);
        return (shift > 0) ? (1 << (shift - 1)) : 0;
    endfunction

endpackage

// File: rtl/fir2d_line_buffer.sv
// rtl/fir2d_line_buffer.sv - K-1 cascaded line RAMs producing one K-tall column per pixel
module fir2d_line_buffer
    import fir2d_pkg::*;
#(
    parameter int PIX_W    = 8,
    parameter int K        = K_DEF,
    parameter int MAX_COLS = 1600,
    parameter int AW       = $clog2(MAX_COLS)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      en,
    input  logic [AW-1:0]             addr,
    input  logic [PIX_W-1:0]          din,
    output logic [K-1:0][PIX_W-1:0]   column
);

    // mem[0] holds the previous line, mem[K-2] the oldest one.
    logic [PIX_W-1:0] mem [K-1][MAX_COLS];

    // Each accepted pixel pushes its column one line deeper (read-before-write cascade).
    always_ff @(posedge clk) begin
        if (en) begin
            mem[0][addr] <= din;
            for (int j = 1; j < K - 1; j++) begin
                mem[j][addr] <= mem[j-1][addr];
            end
        end
    end

    // Registered column: bottom row is the incoming pixel, top row the oldest line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            column <= '0;
        end else if (en) begin
            column[K-1] <= din;
            for (int j = 0; j < K - 1; j++) begin
                column[K-2-j] <= mem[j][addr];
            end
        end
    end

endmodule

// File: rtl/fir2d_kxk_filter.sv
// rtl/fir2d_kxk_filter.sv - KxK 2D FIR on an 8-bit luma stream with frame-synchronous coefficients
module fir2d_kxk_filter
    import fir2d_pkg::*;
#(
    parameter int PIX_W    = 8,
    parameter int K        = K_DEF,
    parameter int COEF_W   = COEF_W_DEF,
    parameter int SHIFT    = 0,
    parameter int MAX_COLS = 1600,
    parameter int MAX_ROWS = 900
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [PIX_W-1:0]            y_i,
    input  logic                        dv_i,
    input  logic                        hs_i,
    input  logic                        vs_i,
    input  logic                        coef_we_i,
    input  logic [$clog2(K*K)-1:0]      coef_addr_i,
    input  logic signed [COEF_W-1:0]    coef_data_i,
    input  logic                        bypass_i,
    output logic [PIX_W-1:0]            r_o,
    output logic [PIX_W-1:0]            g_o,
    output logic [PIX_W-1:0]            b_o,
    output logic                        dv_o,
    output logic                        hs_o,
    output logic                        vs_o
);

    localparam int KK     = K * K;
    localparam int AW     = $clog2(KK);
    localparam int CW     = $clog2(MAX_COLS);
    localparam int RW     = $clog2(MAX_ROWS);
    localparam int PROD_W = PIX_W + 1 + COEF_W;
    localparam int ACC_W  = fir2d_acc_w(PIX_W, COEF_W, K);
    localparam logic signed [ACC_W-1:0] RND     = ACC_W'(fir2d_round_add(SHIFT));
    localparam logic signed [ACC_W-1:0] PIX_MAX = ACC_W'((1 << PIX_W) - 1);

    logic [CW-1:0]                  col;
    logic [RW-1:0]                  row;
    logic                           line_has_dv;
    logic                           vs_q;
    logic                           vs_rise;
    logic signed [COEF_W-1:0]       shadow [KK];
    logic signed [COEF_W-1:0]       active [KK];
    logic [K-1:0][PIX_W-1:0]        column;
    logic [K-2:0][K-1:0][PIX_W-1:0] win_old;
    logic [PIX_W-1:0]               tap [KK];
    logic signed [PROD_W-1:0]       prod [KK];
    logic signed [ACC_W-1:0]        sum_c;
    logic signed [ACC_W-1:0]        acc_s3;
    logic signed [ACC_W-1:0]        rounded;
    logic signed [ACC_W-1:0]        shifted;
    logic [PIX_W-1:0]               sat;
    logic [PIX_W-1:0]               y_s1, y_s2, y_s3;
    logic                           bp_s1, bp_s2, bp_s3;
    logic                           border_s1, border_s2, border_s3;
    logic [PIX_W-1:0]               pix_q;
    logic [LAT-1:0][2:0]            tim_d;

    assign vs_rise = vs_i & ~vs_q;

    // Pixel position: the pixel is counted before hs clears the column; rows only count non-empty lines.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col         <= '0;
            row         <= '0;
            line_has_dv <= 1'b0;
            vs_q        <= 1'b0;
        end else begin
            vs_q <= vs_i;
            if (hs_i) begin
                col <= '0;
            end else if (dv_i && col != CW'(MAX_COLS - 1)) begin
                col <= col + 1'b1;
            end
            if (vs_i) begin
                row <= '0;
            end else if (hs_i && (line_has_dv || dv_i) && row != RW'(MAX_ROWS - 1)) begin
                row <= row + 1'b1;
            end
            if (hs_i) begin
                line_has_dv <= 1'b0;
            end else if (dv_i) begin
                line_has_dv <= 1'b1;
            end
        end
    end

    // Shadow takes writes at any time; active only changes on a vs rise, so frames never see partial updates.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < KK; i++) begin
                shadow[i] <= COEF_W'(fir2d_identity(i, K, SHIFT));
                active[i] <= COEF_W'(fir2d_identity(i, K, SHIFT));
            end
        end else begin
            if (vs_rise) begin
                active <= shadow;
            end
            if (coef_we_i && coef_addr_i < AW'(KK)) begin
                shadow[coef_addr_i] <= coef_data_i;
            end
        end
    end

    fir2d_line_buffer #(
        .PIX_W    (PIX_W),
        .K        (K),
        .MAX_COLS (MAX_COLS),
        .AW       (CW)
    ) u_line_buffer (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (dv_i),
        .addr   (col),
        .din    (y_i),
        .column (column)
    );

    // Stage 1: older window columns shift on each accepted pixel; side-band data registered every cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_old   <= '0;
            y_s1      <= '0;
            bp_s1     <= 1'b0;
            border_s1 <= 1'b0;
        end else begin
            if (dv_i) begin
                win_old <= {column, win_old[K-2:1]};
            end
            y_s1      <= y_i;
            bp_s1     <= bypass_i;
            border_s1 <= (row < RW'(K - 1)) || (col < CW'(K - 1));
        end
    end

    // Tap (r,c): the newest column comes straight from the line buffer, older ones from win_old.
    for (genvar r = 0; r < K; r++) begin : g_tap_row
        for (genvar c = 0; c < K; c++) begin : g_tap_col
            if (c == K - 1) begin : g_new
                assign tap[r*K+c] = column[r];
            end else begin : g_old
                assign tap[r*K+c] = win_old[c][r];
            end
        end
    end

    // Stage 2: signed products of zero-extended pixels with the active coefficients.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < KK; i++) begin
                prod[i] <= '0;
            end
            y_s2      <= '0;
            bp_s2     <= 1'b0;
            border_s2 <= 1'b0;
        end else begin
            for (int i = 0; i < KK; i++) begin
                prod[i] <= PROD_W'($signed({1'b0, tap[i]})) * PROD_W'(active[i]);
            end
            y_s2      <= y_s1;
            bp_s2     <= bp_s1;
            border_s2 <= border_s1;
        end
    end

    // Full-precision sum of all products.
    always_comb begin
        sum_c = '0;
        for (int i = 0; i < KK; i++) begin
            sum_c = sum_c + ACC_W'(prod[i]);
        end
    end

    // Stage 3: adder tree result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_s3    <= '0;
            y_s3      <= '0;
            bp_s3     <= 1'b0;
            border_s3 <= 1'b0;
        end else begin
            acc_s3    <= sum_c;
            y_s3      <= y_s2;
            bp_s3     <= bp_s2;
            border_s3 <= border_s2;
        end
    end

    // Round half up, normalise, then clamp into the unsigned pixel range.
    always_comb begin
        rounded = acc_s3 + RND;
        shifted = rounded >>> SHIFT;
        if (shifted[ACC_W-1]) begin
            sat = '0;
        end else if (shifted > PIX_MAX) begin
            sat = '1;
        end else begin
            sat = shifted[PIX_W-1:0];
        end
    end

    // Stage 4: bypass wins over border zeroing, which wins over the filtered value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix_q <= '0;
        end else if (bp_s3) begin
            pix_q <= y_s3;
        end else if (border_s3) begin
            pix_q <= '0;
        end else begin
            pix_q <= sat;
        end
    end

    // Timing signals are pure LAT-cycle delays of the inputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tim_d <= '0;
        end else begin
            tim_d <= {tim_d[LAT-2:0], {dv_i, hs_i, vs_i}};
        end
    end

    assign r_o  = pix_q;
    assign g_o  = pix_q;
    assign b_o  = pix_q;
    assign dv_o = tim_d[LAT-1][2];
    assign hs_o = tim_d[LAT-1][1];
    assign vs_o = tim_d[LAT-1][0];

endmodule

// File: tb/tb_fir2d_kxk_filter.sv
// tb/tb_fir2d_kxk_filter.sv - self-checking bench for fir2d_kxk_filter with SHIFT=0 and SHIFT=3 instances
module tb_fir2d_kxk_filter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] y_i;
    logic       dv_i, hs_i, vs_i, coef_we_i, bypass_i;
    logic [3:0] coef_addr_i;
    logic [7:0] coef_data_i;
    logic [7:0] r0, g0, b0, r3, g3, b3;
    logic       dv0, hs0, vs0, dv3, hs3, vs3;

    typedef struct {
        bit         dv;
        bit         hs;
        bit         vs;
        logic [7:0] d0;
        logic [7:0] d3;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   img [16][16];
    int   sh0 [9];
    int   act0[9];
    int   sh3 [9];
    int   act3[9];
    int   kern[9];
    int   m_row, m_col;
    bit   m_has, vs_prev;

    always #5 clk = ~clk;

    fir2d_kxk_filter #(.SHIFT(0)) u0 (
        .clk(clk), .rst_n(rst_n), .y_i(y_i), .dv_i(dv_i), .hs_i(hs_i), .vs_i(vs_i),
        .coef_we_i(coef_we_i), .coef_addr_i(coef_addr_i), .coef_data_i(coef_data_i),
        .bypass_i(bypass_i), .r_o(r0), .g_o(g0), .b_o(b0), .dv_o(dv0), .hs_o(hs0), .vs_o(vs0)
    );

    fir2d_kxk_filter #(.SHIFT(3)) u3 (
        .clk(clk), .rst_n(rst_n), .y_i(y_i), .dv_i(dv_i), .hs_i(hs_i), .vs_i(vs_i),
        .coef_we_i(coef_we_i), .coef_addr_i(coef_addr_i), .coef_data_i(coef_data_i),
        .bypass_i(bypass_i), .r_o(r3), .g_o(g3), .b_o(b3), .dv_o(dv3), .hs_o(hs3), .vs_o(vs3)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s got %0h expected %0h", tag, got, want);
        end
    endtask

    // Expected output from the convolution definition over the captured image.
    function automatic logic [7:0] expect_pix(input int r, input int c, input bit bp,
                                              input int coef[9], input int shift);
        int s;
        if (bp) return 8'(img[r][c]);
        if (r < 2 || c < 2) return 8'd0;
        s = 0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                s += coef[i*3+j] * img[r-2+i][c-2+j];
        if (shift > 0) s += 1 << (shift - 1);
        s = s >>> shift;
        if (s < 0) return 8'd0;
        if (s > 255) return 8'd255;
        return 8'(s);
    endfunction

    task automatic check_out(input exp_t e);
        chk("dv_o_s0", dv0, e.dv);
        chk("hs_o_s0", hs0, e.hs);
        chk("vs_o_s0", vs0, e.vs);
        chk("dv_o_s3", dv3, e.dv);
        chk("hs_o_s3", hs3, e.hs);
        chk("vs_o_s3", vs3, e.vs);
        if (e.dv) begin
            chk("r_o_s0", r0, e.d0);
            chk("g_o_s0", g0, e.d0);
            chk("b_o_s0", b0, e.d0);
            chk("r_o_s3", r3, e.d3);
            chk("g_o_s3", g3, e.d3);
            chk("b_o_s3", b3, e.d3);
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_r0"}, r0, 0);  chk({tag, "_g0"}, g0, 0);  chk({tag, "_b0"}, b0, 0);
        chk({tag, "_dv0"}, dv0, 0); chk({tag, "_hs0"}, hs0, 0); chk({tag, "_vs0"}, vs0, 0);
        chk({tag, "_r3"}, r3, 0);  chk({tag, "_g3"}, g3, 0);  chk({tag, "_b3"}, b3, 0);
        chk({tag, "_dv3"}, dv3, 0); chk({tag, "_hs3"}, hs3, 0); chk({tag, "_vs3"}, vs3, 0);
    endtask

    // Model state after reset: identity kernels, counters cleared, pipeline full of idle cycles.
    task automatic reset_model();
        exp_t z;
        for (int i = 0; i < 9; i++) begin
            sh0[i] = (i == 4) ? 1 : 0;
            sh3[i] = (i == 4) ? 8 : 0;
        end
        act0 = sh0;
        act3 = sh3;
        m_row = 0; m_col = 0; m_has = 0; vs_prev = 0;
        exp_q.delete();
        z.dv = 0; z.hs = 0; z.vs = 0; z.d0 = 0; z.d3 = 0;
        repeat (4) exp_q.push_back(z);
        y_i = 0; dv_i = 0; hs_i = 0; vs_i = 0;
        coef_we_i = 0; coef_addr_i = 0; coef_data_i = 0; bypass_i = 0;
    endtask

    task automatic step(input bit dv, input bit hs, input bit vs, input logic [7:0] y,
                        input bit bp, input bit we, input logic [3:0] addr, input logic [7:0] data);
        exp_t e;
        @(negedge clk);
        if (exp_q.size() == 4) check_out(exp_q.pop_front());
        y_i = y; dv_i = dv; hs_i = hs; vs_i = vs; bypass_i = bp;
        coef_we_i = we; coef_addr_i = addr; coef_data_i = data;
        if (vs && !vs_prev) begin
            act0 = sh0;
            act3 = sh3;
        end
        vs_prev = vs;
        if (we && addr < 9) begin
            sh0[addr] = int'($signed(data));
            sh3[addr] = int'($signed(data));
        end
        e.dv = dv; e.hs = hs; e.vs = vs; e.d0 = 0; e.d3 = 0;
        if (dv) begin
            img[m_row][m_col] = y;
            e.d0 = expect_pix(m_row, m_col, bp, act0, 0);
            e.d3 = expect_pix(m_row, m_col, bp, act3, 3);
            if (m_col < 1599) m_col++;
            m_has = 1;
        end
        if (hs) begin
            if (m_has && m_row < 899) m_row++;
            m_col = 0;
            m_has = 0;
        end
        if (vs) m_row = 0;
        exp_q.push_back(e);
    endtask

    task automatic idle();
        step(0, 0, 0, 8'd0, 0, 0, 4'd0, 8'd0);
    endtask

    task automatic write_kernel();
        for (int i = 0; i < 9; i++) step(0, 0, 0, 8'd0, 0, 1, 4'(i), 8'(kern[i]));
        step(0, 0, 0, 8'd0, 0, 1, 4'(9 + $urandom_range(0, 6)), 8'h7f);
    endtask

    task automatic send_frame(input int w, input int h, input int mode, input int cval,
                              input int bp_lo, input int bp_hi, input bit hs_last,
                              input int wr_line, input bit vs_wr, input logic [7:0] vs_data,
                              input int abort_at);
        logic [7:0] y;
        step(0, 0, 1, 8'd0, 0, vs_wr, 4'd4, vs_data);
        idle();
        for (int r = 0; r < h; r++) begin
            for (int c = 0; c < w; c++) begin
                case (mode)
                    0:       y = 8'(r * 16 + c);
                    1:       y = 8'(cval);
                    2:       y = (c < w / 2) ? 8'd0 : 8'd255;
                    default: y = 8'($urandom_range(0, 255));
                endcase
                step(1, hs_last && (c == w - 1), 0, y, (c >= bp_lo) && (c <= bp_hi), 0, 4'd0, 8'd0);
                if (r * w + c == abort_at) return;
            end
            if (!hs_last) step(0, 1, 0, 8'd0, 0, 0, 4'd0, 8'd0);
            idle();
            idle();
            if (r == wr_line) write_kernel();
        end
        idle();
        idle();
    endtask

    initial begin
        rst_n = 1'b0;
        reset_model();
        repeat (3) @(negedge clk);
        #1;
        check_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Identity kernel, ramp image: output is the input shifted one row and one column.
        send_frame(8, 4, 0, 0, 99, 99, 0, -1, 0, 8'd0, -1);

        // Box kernel on flat fields, including saturation.
        for (int i = 0; i < 9; i++) kern[i] = 1;
        write_kernel();
        send_frame(8, 4, 1, 80, 99, 99, 0, -1, 0, 8'd0, -1);
        send_frame(8, 4, 1, 255, 99, 99, 0, -1, 0, 8'd0, -1);

        // Sharpening kernel: flat field and a vertical step edge.
        for (int i = 0; i < 9; i++) kern[i] = (i == 4) ? 9 : -1;
        write_kernel();
        send_frame(8, 4, 1, 200, 99, 99, 0, -1, 0, 8'd0, -1);
        send_frame(8, 5, 2, 0, 99, 99, 0, -1, 0, 8'd0, -1);

        // Mid-frame write stays pending; a write on the vs rise waits one more frame.
        for (int i = 0; i < 9; i++) kern[i] = 1;
        send_frame(8, 4, 3, 0, 99, 99, 0, 1, 0, 8'd0, -1);
        send_frame(8, 4, 3, 0, 99, 99, 0, -1, 1, 8'd5, -1);
        send_frame(8, 4, 3, 0, 99, 99, 0, -1, 0, 8'd0, -1);

        // Bypass on columns 3-5 across every row, border rows included.
        for (int i = 0; i < 9; i++) kern[i] = (i == 4) ? 1 : 0;
        write_kernel();
        send_frame(8, 4, 3, 0, 3, 5, 0, -1, 0, 8'd0, -1);

        // Random kernel and image, hs coinciding with the last pixel of each line.
        for (int i = 0; i < 9; i++) kern[i] = int'($urandom_range(0, 16)) - 8;
        write_kernel();
        send_frame(7, 5, 3, 0, 99, 99, 1, -1, 0, 8'd0, -1);

        // Reset in the middle of a line, then the ramp frame again.
        for (int i = 0; i < 9; i++) kern[i] = (i == 4) ? 1 : 0;
        write_kernel();
        send_frame(8, 4, 0, 0, 99, 99, 0, -1, 0, 8'd0, 2 * 8 + 5);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_zero("midreset");
        reset_model();
        @(negedge clk);
        rst_n = 1'b1;
        send_frame(8, 4, 0, 0, 99, 99, 1, -1, 0, 8'd0, -1);
        repeat (6) idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
